// File: rtl/dual_interrupt_uart.sv
// Two interrupt sources (external pin, periodic timer) latched, arbitrated and
// answered with a fixed ASCII message on a transmit-only 8N1 UART.
module dual_interrupt_uart #(
  parameter int CLK_FREQ_HZ  = 10_000_000,
  parameter int BAUD         = 115200,
  parameter int BAUD_DIV     = (CLK_FREQ_HZ + BAUD / 2) / BAUD,
  parameter int TIMER_PERIOD = 20000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_uart_tx,
  input  logic i_interrupt
);

  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam int TW = $clog2(TIMER_PERIOD);
  localparam logic MSG_EXT = 1'b0;
  localparam logic MSG_TMR = 1'b1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [TW-1:0]   tmr_cnt_q, tmr_cnt_d;
  logic            ext_pend_q, ext_pend_d;
  logic            tmr_pend_q, tmr_pend_d;
  logic            msg_q, msg_d;
  logic            chr_q, chr_d;
  logic [3:0]      bit_q, bit_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic            tx_q, tx_d;

  logic ext_pulse, tmr_wrap;
  logic bit_end, chr_end, msg_end, can_launch, launch_ext, launch_tmr;
  logic clr_ext, clr_tmr;

  function automatic logic [7:0] rom_char(input logic msg, input logic chr);
    if (msg == MSG_TMR) return 8'h54;
    return chr ? 8'h0A : 8'h49;
  endfunction

  // Frame is start(0), d[0]..d[7], stop(1); idx selects the bit on the line.
  function automatic logic frame_bit(input logic [7:0] ch, input logic [3:0] idx);
    logic [9:0] frame;
    frame = {1'b1, ch, 1'b0};
    return frame[idx];
  endfunction

  assign ext_pulse = sync2_q & ~prev_q;
  assign tmr_wrap  = (tmr_cnt_q == TW'(TIMER_PERIOD - 1));
  assign tmr_cnt_d = tmr_wrap ? '0 : tmr_cnt_q + 1'b1;

  assign bit_end    = (state_q == S_SEND) && (baud_q == BW'(BAUD_DIV - 1));
  assign chr_end    = bit_end && (bit_q == 4'd9);
  assign msg_end    = chr_end && (chr_q == (msg_q == MSG_EXT));
  // A finishing message hands over directly so messages run back-to-back.
  assign can_launch = (state_q == S_IDLE) || msg_end;
  assign launch_ext = can_launch && ext_pend_q;
  assign launch_tmr = can_launch && !ext_pend_q && tmr_pend_q;

  assign ext_pend_d = ext_pulse | (ext_pend_q & ~clr_ext);
  assign tmr_pend_d = tmr_wrap  | (tmr_pend_q & ~clr_tmr);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (launch_ext || launch_tmr) state_d = S_SEND;
      S_SEND: if (msg_end && !(launch_ext || launch_tmr)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    msg_d   = msg_q;
    chr_d   = chr_q;
    bit_d   = bit_q;
    baud_d  = baud_q + 1'b1;
    tx_d    = tx_q;
    clr_ext = 1'b0;
    clr_tmr = 1'b0;
    if (launch_ext || launch_tmr) begin
      msg_d   = launch_tmr ? MSG_TMR : MSG_EXT;
      chr_d   = 1'b0;
      bit_d   = 4'd0;
      baud_d  = '0;
      tx_d    = 1'b0;
      clr_ext = launch_ext;
      clr_tmr = launch_tmr;
    end else if (state_q == S_SEND) begin
      if (bit_end) begin
        baud_d = '0;
        if (msg_end) begin
          tx_d  = 1'b1;
          bit_d = 4'd0;
          chr_d = 1'b0;
        end else if (chr_end) begin
          chr_d = ~chr_q;
          bit_d = 4'd0;
          tx_d  = 1'b0;
        end else begin
          bit_d = bit_q + 4'd1;
          tx_d  = frame_bit(rom_char(msg_q, chr_q), bit_q + 4'd1);
        end
      end
    end else begin
      baud_d = '0;
      tx_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      tmr_cnt_q  <= '0;
      ext_pend_q <= 1'b0;
      tmr_pend_q <= 1'b0;
      msg_q      <= MSG_EXT;
      chr_q      <= 1'b0;
      bit_q      <= 4'd0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      sync1_q    <= i_interrupt;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      tmr_cnt_q  <= tmr_cnt_d;
      ext_pend_q <= ext_pend_d;
      tmr_pend_q <= tmr_pend_d;
      msg_q      <= msg_d;
      chr_q      <= chr_d;
      bit_q      <= bit_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
    end
  end

  assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_dual_interrupt_uart.sv
// Random interrupt stimulus against a message-level model; a UART decoder on
// the line compares every received byte and its start time with the model.
module tb_dual_interrupt_uart;

  localparam int B = 8;
  localparam int P = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic intr = 1'b0;
  logic tx;

  always #5 clk = ~clk;

  dual_interrupt_uart #(
    .CLK_FREQ_HZ (10_000_000),
    .BAUD        (115200),
    .BAUD_DIV    (B),
    .TIMER_PERIOD(P)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_uart_tx  (tx),
    .i_interrupt(intr)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  typedef struct {
    int b;
    int t;
  } exp_t;

  exp_t exp_q[$];
  int   n;
  bit   ep, tp;
  int   busy_end;
  bit   h0, h1, h2, h3;

  // Model: n counts clock edges since reset release; a message occupies the
  // line for 10*B clocks per character and a new one may start at its end.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      n = 0; ep = 0; tp = 0; busy_end = 0;
      h0 = 0; h1 = 0; h2 = 0; h3 = 0;
      exp_q.delete();
    end else begin
      n++;
      h3 = h2; h2 = h1; h1 = h0; h0 = intr;
      if (n >= busy_end && (ep || tp)) begin
        if (ep) begin
          exp_q.push_back('{b: 'h49, t: n});
          exp_q.push_back('{b: 'h0A, t: n + 10 * B});
          busy_end = n + 20 * B;
          ep = 0;
        end else begin
          exp_q.push_back('{b: 'h54, t: n});
          busy_end = n + 10 * B;
          tp = 0;
        end
      end
      // Edge seen by the synchronizer two clocks ago becomes pending now.
      if (h2 && !h3) ep = 1;
      if (n % P == 0) tp = 1;
    end
  end

  bit         dbusy = 0;
  int         dstart;
  logic [7:0] dshift;
  int         nbytes = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      dbusy = 0;
      chk("tx_idle_in_reset", tx, 1);
    end else begin
      if (!dbusy && tx == 1'b0) begin
        dbusy  = 1;
        dstart = n;
        dshift = '0;
      end
      if (dbusy && ((n - dstart) % B == B / 2)) begin
        int k;
        k = (n - dstart) / B;
        if (k == 0) chk("start_bit", tx, 0);
        else if (k <= 8) dshift[k-1] = tx;
        else begin
          chk("stop_bit", tx, 1);
          nbytes++;
          $display("tb: byte 0x%02h start edge %0d", dshift, dstart);
          chk("byte_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("byte_value", dshift, e.b);
            chk("byte_start", dstart, e.t);
          end
          dbusy = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int width);
    intr = 1'b1;
    repeat (width) tick();
    intr = 1'b0;
    tick();
  endtask

  initial begin
    int m;
    int target;
    bit done;

    repeat (5) tick();
    rst = 1'b0;

    repeat (49) tick();
    intr = 1'b1;
    m = n;
    tick();
    intr = 1'b0;
    for (int i = 0; i < 10 && tx == 1'b1; i++) tick();
    chk("ext_latency_le6", (tx == 1'b0) && (n - m <= 6), 1);
    repeat (200) tick();

    target = ((n / P) + 1) * P - 3;
    if (target <= n) target += P;
    while (n < target) tick();
    pulse(1);
    repeat (400) tick();

    pulse(1);
    repeat (20) tick();
    pulse(2);
    repeat (20) tick();
    pulse(1);
    repeat (400) tick();

    intr = 1'b1;
    repeat (1000) tick();
    intr = 1'b0;
    repeat (300) tick();

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(1, 250)) tick();
      pulse($urandom_range(1, 4));
    end

    for (int i = 0; i < 1000 && tx != 1'b0; i++) tick();
    chk("tx_activity_before_reset", tx == 1'b0, 1);
    repeat ($urandom_range(0, 3)) begin
      tick();
      if (tx != 1'b0) break;
    end
    if (tx == 1'b0) begin
      #1 rst = 1'b1;
      #1 chk("tx_async_reset", tx, 1);
    end else begin
      #1 rst = 1'b1;
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (700) tick();

    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(1, 200)) tick();
      pulse($urandom_range(1, 3));
    end

    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      done = (exp_q.size() == 0) && !dbusy;
    end
    chk("drain_complete", done, 1);
    chk("bytes_seen", nbytes > 20, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
